// File: rtl/fsm_pkg.sv
// Shared widths, one-hot state encodings and the threshold pair type
// for the five-FIFO flow-control block.
package fsm_pkg;

    localparam int TH_W  = 5;
    localparam int NFIFO = 5;

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    typedef enum logic [4:0] {
        ST_RESET  = S_RESET,
        ST_INIT   = S_INIT,
        ST_IDLE   = S_IDLE,
        ST_ACTIVE = S_ACTIVE,
        ST_ERROR  = S_ERROR
    } state_e;

    typedef struct packed {
        logic [TH_W-1:0] low;
        logic [TH_W-1:0] high;
    } th_pair_t;

endpackage

// File: rtl/fsm_cfg_regs.sv
// Per-FIFO low/high threshold registers, loaded while the FSM sits in INIT,
// plus the check that every captured pair is ordered low < high.
module fsm_cfg_regs
    import fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  th_pair_t [NFIFO-1:0] th_in,
    output th_pair_t [NFIFO-1:0] th_q,
    output logic                 cfg_ok
);

    logic [NFIFO-1:0] pair_ok;

    for (genvar i = 0; i < NFIFO; i++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                th_q[i] <= '0;
            else if (load)
                th_q[i] <= th_in[i];
        end

        assign pair_ok[i] = th_q[i].low < th_q[i].high;
    end

    assign cfg_ok = &pair_ok;

endmodule

// File: rtl/fsm_ctrl.sv
// Flow-control FSM: RESET -> INIT -> IDLE/ACTIVE with a sticky ERROR,
// distributing the INIT-captured thresholds to all five FIFOs.
module fsm_ctrl
    import fsm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [TH_W-1:0]  main_fifo_low,
    input  logic [TH_W-1:0]  main_fifo_high,
    input  logic [TH_W-1:0]  Vco_low,
    input  logic [TH_W-1:0]  Vco_high,
    input  logic [TH_W-1:0]  Vc1_low,
    input  logic [TH_W-1:0]  Vc1_high,
    input  logic [TH_W-1:0]  Do_low,
    input  logic [TH_W-1:0]  Do_high,
    input  logic [TH_W-1:0]  D1_low,
    input  logic [TH_W-1:0]  D1_high,
    input  logic [NFIFO-1:0] empties,
    input  logic [NFIFO-1:0] errors,
    output logic [TH_W-1:0]  main_fifo_low_o,
    output logic [TH_W-1:0]  main_fifo_high_o,
    output logic [TH_W-1:0]  Vco_low_o,
    output logic [TH_W-1:0]  Vco_high_o,
    output logic [TH_W-1:0]  Vc1_low_o,
    output logic [TH_W-1:0]  Vc1_high_o,
    output logic [TH_W-1:0]  Do_low_o,
    output logic [TH_W-1:0]  Do_high_o,
    output logic [TH_W-1:0]  D1_low_o,
    output logic [TH_W-1:0]  D1_high_o,
    output logic [4:0]       state_o,
    output logic             idle_o,
    output logic             active_o,
    output logic             error_o,
    output logic             cfg_err_o,
    output logic [NFIFO-1:0] error_full_o
);

    // Plain vector so that illegal encodings are representable and recoverable.
    logic [4:0]           state_q;
    state_e               state_d;
    th_pair_t [NFIFO-1:0] th_in;
    th_pair_t [NFIFO-1:0] th_q;
    logic                 cfg_ok;
    logic                 any_err;

    assign th_in[0] = '{low: main_fifo_low, high: main_fifo_high};
    assign th_in[1] = '{low: Vco_low,       high: Vco_high};
    assign th_in[2] = '{low: Vc1_low,       high: Vc1_high};
    assign th_in[3] = '{low: Do_low,        high: Do_high};
    assign th_in[4] = '{low: D1_low,        high: D1_high};

    fsm_cfg_regs u_cfg (
        .clk    (clk),
        .rst_n  (reset),
        .load   (state_q == S_INIT),
        .th_in  (th_in),
        .th_q   (th_q),
        .cfg_ok (cfg_ok)
    );

    assign any_err = |errors;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    // Errors outrank init and empties changes in every operational state.
    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            S_RESET:  state_d = ST_INIT;
            S_INIT: begin
                if (any_err)             state_d = ST_ERROR;
                else if (!init && cfg_ok) state_d = ST_IDLE;
                else                     state_d = ST_INIT;
            end
            S_IDLE: begin
                if (any_err)        state_d = ST_ERROR;
                else if (init)      state_d = ST_INIT;
                else if (~&empties) state_d = ST_ACTIVE;
                else                state_d = ST_IDLE;
            end
            S_ACTIVE: begin
                if (any_err)       state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (&empties) state_d = ST_IDLE;
                else               state_d = ST_ACTIVE;
            end
            S_ERROR:  state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            error_full_o <= '0;
        else if (state_q != S_RESET)
            error_full_o <= error_full_o | errors;
    end

    assign state_o   = state_q;
    assign idle_o    = (state_q == S_IDLE);
    assign active_o  = (state_q == S_ACTIVE);
    assign error_o   = (state_q == S_ERROR);
    assign cfg_err_o = (state_q == S_INIT) && !cfg_ok;

    assign main_fifo_low_o  = th_q[0].low;
    assign main_fifo_high_o = th_q[0].high;
    assign Vco_low_o        = th_q[1].low;
    assign Vco_high_o       = th_q[1].high;
    assign Vc1_low_o        = th_q[2].low;
    assign Vc1_high_o       = th_q[2].high;
    assign Do_low_o         = th_q[3].low;
    assign Do_high_o        = th_q[3].high;
    assign D1_low_o         = th_q[4].low;
    assign D1_high_o        = th_q[4].high;

endmodule

// File: tb/tb_fsm_ctrl.sv
// Directed scoreboard bench for fsm_ctrl: expected snapshots are queued as
// stimulus is applied and checked one cycle later against the outputs.
module tb_fsm_ctrl;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            init = 1'b0;
    logic [9:0][4:0] th_in;
    wire  [9:0][4:0] th_out;
    logic [4:0]      empties = 5'b11111;
    logic [4:0]      errors = 5'b00000;
    wire  [4:0]      state_o;
    wire             idle_o, active_o, error_o, cfg_err_o;
    wire  [4:0]      error_full_o;

    typedef struct packed {
        logic [4:0]  st;
        logic        cfg;
        logic [4:0]  ef;
        logic [49:0] thr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [9:0][4:0] TZ, TBAD, TGOOD;

    always #5 clk = ~clk;

    fsm_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .init             (init),
        .main_fifo_low    (th_in[0]),
        .main_fifo_high   (th_in[1]),
        .Vco_low          (th_in[2]),
        .Vco_high         (th_in[3]),
        .Vc1_low          (th_in[4]),
        .Vc1_high         (th_in[5]),
        .Do_low           (th_in[6]),
        .Do_high          (th_in[7]),
        .D1_low           (th_in[8]),
        .D1_high          (th_in[9]),
        .empties          (empties),
        .errors           (errors),
        .main_fifo_low_o  (th_out[0]),
        .main_fifo_high_o (th_out[1]),
        .Vco_low_o        (th_out[2]),
        .Vco_high_o       (th_out[3]),
        .Vc1_low_o        (th_out[4]),
        .Vc1_high_o       (th_out[5]),
        .Do_low_o         (th_out[6]),
        .Do_high_o        (th_out[7]),
        .D1_low_o         (th_out[8]),
        .D1_high_o        (th_out[9]),
        .state_o          (state_o),
        .idle_o           (idle_o),
        .active_o         (active_o),
        .error_o          (error_o),
        .cfg_err_o        (cfg_err_o),
        .error_full_o     (error_full_o)
    );

    function automatic logic [9:0][4:0] mk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8,
                                           input int a9);
        logic [9:0][4:0] r;
        r[0] = a0[4:0]; r[1] = a1[4:0]; r[2] = a2[4:0]; r[3] = a3[4:0];
        r[4] = a4[4:0]; r[5] = a5[4:0]; r[6] = a6[4:0]; r[7] = a7[4:0];
        r[8] = a8[4:0]; r[9] = a9[4:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] st, input logic cfg, input logic [4:0] ef,
                        input logic [49:0] thr);
        exp_t e;
        e.st = st; e.cfg = cfg; e.ef = ef; e.thr = thr;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk("state",      64'(state_o), 64'(e.st));
        chk("decodes",    64'({idle_o, active_o, error_o}),
            64'({e.st == 5'b00100, e.st == 5'b01000, e.st == 5'b10000}));
        chk("cfg_err",    64'(cfg_err_o), 64'(e.cfg));
        chk("error_full", 64'(error_full_o), 64'(e.ef));
        chk("thresholds", 64'(th_out), 64'(e.thr));
    endtask

    // Expectation for the outputs after the next rising edge.
    task automatic step(input logic [4:0] st, input logic cfg, input logic [4:0] ef,
                        input logic [49:0] thr);
        push(st, cfg, ef, thr);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Expectation for the outputs as they are right now (between edges).
    task automatic now(input logic [4:0] st, input logic cfg, input logic [4:0] ef,
                       input logic [49:0] thr);
        push(st, cfg, ef, thr);
        compare_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        TZ    = '0;
        TBAD  = mk(3, 6, 'hB, 8, 2, 9, 1, 4, 5, 'hA);
        TGOOD = mk(3, 6, 3, 8, 2, 9, 1, 4, 5, 'hA);
        th_in = TBAD;

        // 1: reset state, then INIT holds while VC0 is misordered
        #12;
        now(5'b00001, 1'b0, 5'b0, TZ);
        @(posedge clk); #1;
        reset = 1'b1;
        step(5'b00010, 1'b1, 5'b0, TZ);
        step(5'b00010, 1'b1, 5'b0, TBAD);
        step(5'b00010, 1'b1, 5'b0, TBAD);
        th_in = TGOOD;
        step(5'b00010, 1'b0, 5'b0, TGOOD);
        step(5'b00100, 1'b0, 5'b0, TGOOD);

        // 2: IDLE <-> ACTIVE on the empties AND
        empties = 5'b11110;
        step(5'b01000, 1'b0, 5'b0, TGOOD);
        empties = 5'b11111;
        step(5'b00100, 1'b0, 5'b0, TGOOD);
        empties = 5'b11110;
        step(5'b01000, 1'b0, 5'b0, TGOOD);

        // 3: thresholds frozen outside INIT; init held across the INIT entry
        //    edge so the zero values are captured before cfg_ok is evaluated
        th_in = TZ;
        step(5'b01000, 1'b0, 5'b0, TGOOD);
        init = 1'b1;
        step(5'b00010, 1'b0, 5'b0, TGOOD);
        step(5'b00010, 1'b1, 5'b0, TZ);
        init = 1'b0;
        step(5'b00010, 1'b1, 5'b0, TZ);
        th_in   = TGOOD;
        empties = 5'b11111;
        step(5'b00010, 1'b0, 5'b0, TGOOD);
        step(5'b00100, 1'b0, 5'b0, TGOOD);

        // 4: errors beat init, error_full accumulates, ERROR is sticky
        errors = 5'b00001;
        init   = 1'b1;
        step(5'b10000, 1'b0, 5'b00001, TGOOD);
        init   = 1'b0;
        errors = 5'b00100;
        step(5'b10000, 1'b0, 5'b00101, TGOOD);
        errors = 5'b00000;
        step(5'b10000, 1'b0, 5'b00101, TGOOD);
        th_in = TZ;
        step(5'b10000, 1'b0, 5'b00101, TGOOD);

        // 5: asynchronous reset mid-cycle, then release
        #2;
        reset = 1'b0;
        #1;
        now(5'b00001, 1'b0, 5'b0, TZ);
        @(posedge clk); #1;
        now(5'b00001, 1'b0, 5'b0, TZ);
        reset = 1'b1;
        step(5'b00010, 1'b1, 5'b0, TZ);
        th_in = TGOOD;
        step(5'b00010, 1'b0, 5'b0, TGOOD);

        // 6: illegal encoding recovers through RESET
        force dut.state_q = 5'b00011;
        #1;
        release dut.state_q;
        now(5'b00011, 1'b0, 5'b0, TGOOD);
        step(5'b00001, 1'b0, 5'b0, TGOOD);
        step(5'b00010, 1'b0, 5'b0, TGOOD);
        step(5'b00100, 1'b0, 5'b0, TGOOD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
